// File: rtl/iic_req_arbiter.sv
// ---------------------------------------------------------------------------
// iic_req_arbiter
//
// Two-requester round-robin front end for a single IIC byte engine.
// The FSM runs IDLE -> START -> WAIT -> RESP -> IDLE and every output is a
// register.
//   IDLE : pick a requester, latch its rnw/addr/wdata, pulse gntX.
//   START: pulse eng_start.
//   WAIT : wait for eng_done, then capture eng_rdata/eng_ack_err.
//   RESP : pulse doneX with rdataX/errX, then hand priority to the other
//          requester.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   req0/1, rnw0/1, addr0/1,
//   wdata0/1                       per-requester command inputs
//   gnt0/1, done0/1, rdata0/1,
//   err0/1                         per-requester handshake / response
//   eng_start, eng_rnw, eng_addr,
//   eng_wdata, eng_abort           command to the byte engine
//   eng_busy, eng_done, eng_rdata,
//   eng_ack_err                    status from the byte engine
//   busy                           high in every state except IDLE
//
// Build option
//   IIC_ARB_TIMEOUT_EN : when defined, WAIT is bounded by TIMEOUT_CYCLES
//   clk cycles. On expiry eng_abort pulses and the requester receives
//   doneX with errX=1 and rdataX=0x00. When undefined, no counter is built,
//   eng_abort is constant 0, and WAIT lasts until eng_done arrives.
// ---------------------------------------------------------------------------
module iic_req_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              rnw0,
    input  logic              rnw1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [7:0]        wdata0,
    input  logic [7:0]        wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [7:0]        rdata0,
    output logic [7:0]        rdata1,
    output logic              err0,
    output logic              err1,
    output logic              eng_start,
    output logic              eng_rnw,
    output logic [ADDR_W-1:0] eng_addr,
    output logic [7:0]        eng_wdata,
    input  logic              eng_busy,
    input  logic              eng_done,
    input  logic [7:0]        eng_rdata,
    input  logic              eng_ack_err,
    output logic              eng_abort,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t            state_reg, state_next;
    logic              ptr_reg, ptr_next;     // requester favoured when both ask
    logic              sel_reg, sel_next;     // requester currently being served
    logic [1:0]        gnt_reg, gnt_next;
    logic [1:0]        done_reg, done_next;
    logic [1:0]        err_reg, err_next;
    logic [1:0][7:0]   rdata_reg, rdata_next;
    logic              eng_start_reg, eng_start_next;
    logic              eng_rnw_reg, eng_rnw_next;
    logic [ADDR_W-1:0] eng_addr_reg, eng_addr_next;
    logic [7:0]        eng_wdata_reg, eng_wdata_next;
    logic              busy_reg, busy_next;
    logic              pick;

    // A lone requester wins outright; the pointer only breaks ties.
    assign pick = (req0 && req1) ? ptr_reg : req1;

`ifdef IIC_ARB_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             eng_abort_reg, eng_abort_next;

    assign eng_abort = eng_abort_reg;
`else
    // Abort is never raised; the comparison is constant false.
    assign eng_abort = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        sel_next       = sel_reg;
        gnt_next       = 2'b00;
        done_next      = 2'b00;
        err_next       = 2'b00;
        rdata_next     = '0;
        eng_start_next = 1'b0;
        eng_rnw_next   = eng_rnw_reg;
        eng_addr_next  = eng_addr_reg;
        eng_wdata_next = eng_wdata_reg;
`ifdef IIC_ARB_TIMEOUT_EN
        cnt_next       = cnt_reg;
        eng_abort_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (!eng_busy && (req0 || req1)) begin
                    sel_next       = pick;
                    gnt_next[pick] = 1'b1;
                    eng_rnw_next   = pick ? rnw1   : rnw0;
                    eng_addr_next  = pick ? addr1  : addr0;
                    eng_wdata_next = pick ? wdata1 : wdata0;
                    state_next     = START;
                end
            end
            START: begin
                eng_start_next = 1'b1;
                state_next     = WAIT;
`ifdef IIC_ARB_TIMEOUT_EN
                cnt_next       = '0;
`endif
            end
            WAIT: begin
                if (eng_done) begin
                    done_next[sel_reg]  = 1'b1;
                    err_next[sel_reg]   = eng_ack_err;
                    // A write returns no data, whatever the engine drives.
                    rdata_next[sel_reg] = eng_rnw_reg ? eng_rdata : 8'h00;
                    state_next          = RESP;
                end
`ifdef IIC_ARB_TIMEOUT_EN
                else if (cnt_reg == CNT_LAST) begin
                    done_next[sel_reg] = 1'b1;
                    err_next[sel_reg]  = 1'b1;
                    eng_abort_next     = 1'b1;
                    state_next         = RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
            RESP: begin
                ptr_next   = ~sel_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= 1'b0;
            sel_reg       <= 1'b0;
            gnt_reg       <= 2'b00;
            done_reg      <= 2'b00;
            err_reg       <= 2'b00;
            rdata_reg     <= '0;
            eng_start_reg <= 1'b0;
            eng_rnw_reg   <= 1'b0;
            eng_addr_reg  <= '0;
            eng_wdata_reg <= 8'h00;
            busy_reg      <= 1'b0;
`ifdef IIC_ARB_TIMEOUT_EN
            cnt_reg       <= '0;
            eng_abort_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            sel_reg       <= sel_next;
            gnt_reg       <= gnt_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            rdata_reg     <= rdata_next;
            eng_start_reg <= eng_start_next;
            eng_rnw_reg   <= eng_rnw_next;
            eng_addr_reg  <= eng_addr_next;
            eng_wdata_reg <= eng_wdata_next;
            busy_reg      <= busy_next;
`ifdef IIC_ARB_TIMEOUT_EN
            cnt_reg       <= cnt_next;
            eng_abort_reg <= eng_abort_next;
`endif
        end
    end

    assign gnt0      = gnt_reg[0];
    assign gnt1      = gnt_reg[1];
    assign done0     = done_reg[0];
    assign done1     = done_reg[1];
    assign err0      = err_reg[0];
    assign err1      = err_reg[1];
    assign rdata0    = rdata_reg[0];
    assign rdata1    = rdata_reg[1];
    assign eng_start = eng_start_reg;
    assign eng_rnw   = eng_rnw_reg;
    assign eng_addr  = eng_addr_reg;
    assign eng_wdata = eng_wdata_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_iic_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iic_req_arbiter
//
// Self-checking bench for iic_req_arbiter. A transaction-level model tracks
// who was served last and derives the expected winner, command and
// response. Outputs are sampled 1 time unit after the rising edge. Inputs
// are driven at that same point, so they are sampled on the following edge.
// The timeout scenario changes its expectation according to
// IIC_ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_iic_req_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, rnw0 = 1'b0, rnw1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0;
    logic [7:0]  wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic [7:0]  rdata0, rdata1;
    logic        eng_start, eng_rnw, eng_abort, busy;
    logic [15:0] eng_addr;
    logic [7:0]  eng_wdata;
    logic        eng_busy = 1'b0, eng_done = 1'b0, eng_ack_err = 1'b0;
    logic [7:0]  eng_rdata = '0;

    int tests_run = 0;
    int failed    = 0;
    int last_served;   // model: requester served last (1 after reset => req0 favoured)

    // observations gathered by drive_engine
    logic        obs_start, obs_rnw, obs_stray;
    logic [15:0] obs_addr;
    logic [7:0]  obs_wdata, obs_rdata0, obs_rdata1;
    logic        obs_done0, obs_done1, obs_err0, obs_err1, obs_idle_busy;

    iic_req_arbiter #(.ADDR_W(16), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .rnw0(rnw0), .rnw1(rnw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .eng_start(eng_start), .eng_rnw(eng_rnw), .eng_addr(eng_addr),
        .eng_wdata(eng_wdata), .eng_busy(eng_busy), .eng_done(eng_done),
        .eng_rdata(eng_rdata), .eng_ack_err(eng_ack_err),
        .eng_abort(eng_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int model_pick(input logic r0, input logic r1);
        if (r0 && r1) return (last_served == 0) ? 1 : 0;
        return r1 ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the requester granted (-1 none within limit, 2 both) and the
    // number of edges it took.
    task automatic wait_grant(input int limit, output int who, output int cycles);
        who = -1;
        cycles = 0;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (gnt0 || gnt1) begin
                who = (gnt0 && gnt1) ? 2 : (gnt1 ? 1 : 0);
                cycles = i;
                break;
            end
        end
    endtask

    // Called in the grant cycle. Plays the engine: waits `delay` cycles in
    // WAIT, pulses eng_done, and records what the arbiter showed.
    task automatic drive_engine(input int delay, input logic [7:0] rd, input logic ae);
        obs_stray = 1'b0;
        tick();
        obs_start = eng_start;
        obs_rnw   = eng_rnw;
        obs_addr  = eng_addr;
        obs_wdata = eng_wdata;
        if (gnt0 || gnt1 || done0 || done1 || eng_abort) obs_stray = 1'b1;
        repeat (delay) begin
            tick();
            if (gnt0 || gnt1 || done0 || done1 || eng_start || eng_abort) obs_stray = 1'b1;
        end
        eng_done = 1'b1;
        eng_rdata = rd;
        eng_ack_err = ae;
        tick();
        eng_done = 1'b0;
        eng_rdata = 8'($urandom);
        eng_ack_err = 1'($urandom);
        obs_done0 = done0;
        obs_done1 = done1;
        obs_rdata0 = rdata0;
        obs_rdata1 = rdata1;
        obs_err0 = err0;
        obs_err1 = err1;
        tick();
        obs_idle_busy = busy;
        if (done0 || done1) obs_stray = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1, eng_start, eng_rnw,
             eng_addr, eng_wdata, eng_abort, busy} !== '0) begin
            failed++;
            $display("FAIL reset_outputs: got gnt=%b%b done=%b%b busy=%b eng_start=%b addr=%h want all 0",
                     gnt1, gnt0, done1, done0, busy, eng_start, eng_addr);
        end
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        tests_run++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin
            failed++;
            $display("FAIL reset_blocks_grant: got gnt=%b%b busy=%b want 000", gnt1, gnt0, busy);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        rst = 1'b0;
        last_served = 1;
        tick();
    endtask

    task automatic test_single_write();
        int who, cyc;
        req0 = 1'b1;
        rnw0 = 1'b0;
        addr0 = 16'h0010;
        wdata0 = 8'hA5;
        wait_grant(4, who, cyc);
        tests_run++;
        if (who !== 0 || cyc !== 1) begin
            failed++;
            $display("FAIL write_grant: got who=%0d after %0d want who=0 after 1", who, cyc);
        end
        tests_run++;
        if (busy !== 1'b1) begin
            failed++;
            $display("FAIL write_busy: got %b want 1", busy);
        end
        req0 = 1'b0;   // dropping the request must not cancel the transaction
        drive_engine(3, 8'h77, 1'b0);
        tests_run++;
        if ({obs_start, obs_rnw, obs_addr, obs_wdata} !== {1'b1, 1'b0, 16'h0010, 8'hA5}) begin
            failed++;
            $display("FAIL write_cmd: got start=%b rnw=%b addr=%h wdata=%h want 1 0 0010 a5",
                     obs_start, obs_rnw, obs_addr, obs_wdata);
        end
        tests_run++;
        if ({obs_done0, obs_done1, obs_err0, obs_rdata0} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            failed++;
            $display("FAIL write_resp: got done0=%b done1=%b err0=%b rdata0=%h want 1 0 0 00",
                     obs_done0, obs_done1, obs_err0, obs_rdata0);
        end
        tests_run++;
        if (obs_stray !== 1'b0 || obs_idle_busy !== 1'b0) begin
            failed++;
            $display("FAIL write_sequence: got stray=%b idle_busy=%b want 0 0", obs_stray, obs_idle_busy);
        end
        last_served = 0;
        $display("[TB] txn write req0 addr=0010 wdata=a5");
    endtask

    task automatic test_read_err();
        int who, cyc;
        req1 = 1'b1;
        rnw1 = 1'b1;
        addr1 = 16'h1FFF;
        wait_grant(4, who, cyc);
        tests_run++;
        if (who !== 1 || cyc !== 1) begin
            failed++;
            $display("FAIL read_grant: got who=%0d after %0d want who=1 after 1", who, cyc);
        end
        req1 = 1'b0;
        drive_engine(2, 8'h3C, 1'b1);
        tests_run++;
        if ({obs_rnw, obs_addr} !== {1'b1, 16'h1FFF}) begin
            failed++;
            $display("FAIL read_cmd: got rnw=%b addr=%h want 1 1fff", obs_rnw, obs_addr);
        end
        tests_run++;
        if ({obs_done1, obs_rdata1, obs_err1, obs_done0} !== {1'b1, 8'h3C, 1'b1, 1'b0}) begin
            failed++;
            $display("FAIL read_resp: got done1=%b rdata1=%h err1=%b done0=%b want 1 3c 1 0",
                     obs_done1, obs_rdata1, obs_err1, obs_done0);
        end
        last_served = 1;
        $display("[TB] txn read req1 addr=1fff rdata=3c nack");
    endtask

    task automatic test_busy_block();
        int who, cyc;
        logic seen;
        seen = 1'b0;
        eng_busy = 1'b1;
        req0 = 1'b1;
        rnw0 = 1'b1;
        addr0 = 16'h0042;
        repeat (8) begin
            eng_done = 1'($urandom);   // stray engine completions must be ignored
            tick();
            if (gnt0 || gnt1 || done0 || done1 || busy) seen = 1'b1;
        end
        eng_done = 1'b0;
        tests_run++;
        if (seen !== 1'b0) begin
            failed++;
            $display("FAIL busy_no_grant: got activity=%b want 0", seen);
        end
        eng_busy = 1'b0;
        wait_grant(4, who, cyc);
        tests_run++;
        if (who !== 0 || cyc !== 1) begin
            failed++;
            $display("FAIL busy_release_grant: got who=%0d after %0d want who=0 after 1", who, cyc);
        end
        req0 = 1'b0;
        drive_engine(1, 8'h5A, 1'b0);
        tests_run++;
        if ({obs_done0, obs_rdata0, obs_err0} !== {1'b1, 8'h5A, 1'b0}) begin
            failed++;
            $display("FAIL busy_resp: got done0=%b rdata0=%h err0=%b want 1 5a 0",
                     obs_done0, obs_rdata0, obs_err0);
        end
        last_served = 0;
        $display("[TB] txn read req0 after engine busy");
    endtask

    task automatic test_back_to_back();
        int who, cyc, exp_who;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_served = 1;
        req0 = 1'b1;
        req1 = 1'b1;
        rnw0 = 1'b0;
        rnw1 = 1'b0;
        addr0 = 16'hA000;
        addr1 = 16'hB111;
        for (int k = 0; k < 4; k++) begin
            exp_who = model_pick(1'b1, 1'b1);
            wait_grant(4, who, cyc);
            tests_run++;
            if (who !== exp_who || cyc !== 1) begin
                failed++;
                $display("FAIL b2b_grant%0d: got who=%0d after %0d want who=%0d after 1", k, who, cyc, exp_who);
            end
            drive_engine(k, 8'h00, 1'b0);
            tests_run++;
            if (obs_addr !== (exp_who == 1 ? 16'hB111 : 16'hA000) ||
                {obs_done1, obs_done0} !== (exp_who == 1 ? 2'b10 : 2'b01)) begin
                failed++;
                $display("FAIL b2b_resp%0d: got addr=%h done=%b%b want served=%0d",
                         k, obs_addr, obs_done1, obs_done0, exp_who);
            end
            last_served = exp_who;
            $display("[TB] txn back-to-back #%0d served req%0d", k, exp_who);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            int who, cyc, exp_who, dly, ru;
            logic [7:0]  rd;
            logic        ae, e_rnw;
            logic [15:0] e_addr;
            logic [7:0]  e_wd, e_rdata;
            ru = $urandom_range(1, 3);
            req0 = ru[0];
            req1 = ru[1];
            rnw0 = 1'($urandom);
            rnw1 = 1'($urandom);
            addr0 = 16'($urandom);
            addr1 = 16'($urandom);
            wdata0 = 8'($urandom);
            wdata1 = 8'($urandom);
            exp_who = model_pick(req0, req1);
            e_rnw  = exp_who == 1 ? rnw1 : rnw0;
            e_addr = exp_who == 1 ? addr1 : addr0;
            e_wd   = exp_who == 1 ? wdata1 : wdata0;
            wait_grant(4, who, cyc);
            tests_run++;
            if (who !== exp_who || cyc !== 1) begin
                failed++;
                $display("FAIL rand%0d_grant: got who=%0d after %0d want who=%0d after 1", t, who, cyc, exp_who);
            end
            // Inputs now change freely; the latched command must not follow.
            req0 = 1'($urandom);
            req1 = 1'($urandom);
            rnw0 = 1'($urandom);
            rnw1 = 1'($urandom);
            addr0 = 16'($urandom);
            addr1 = 16'($urandom);
            wdata0 = 8'($urandom);
            wdata1 = 8'($urandom);
            dly = $urandom_range(0, 5);
            rd = 8'($urandom);
            ae = 1'($urandom);
            e_rdata = e_rnw ? rd : 8'h00;
            drive_engine(dly, rd, ae);
            tests_run++;
            if ({obs_start, obs_rnw, obs_addr, obs_wdata} !== {1'b1, e_rnw, e_addr, e_wd}) begin
                failed++;
                $display("FAIL rand%0d_cmd: got start=%b rnw=%b addr=%h wdata=%h want 1 %b %h %h",
                         t, obs_start, obs_rnw, obs_addr, obs_wdata, e_rnw, e_addr, e_wd);
            end
            tests_run++;
            if ({obs_done1, obs_done0} !== (exp_who == 1 ? 2'b10 : 2'b01) ||
                (exp_who == 1 ? {obs_rdata1, obs_err1} : {obs_rdata0, obs_err0}) !== {e_rdata, ae}) begin
                failed++;
                $display("FAIL rand%0d_resp: got done=%b%b rdata=%h/%h err=%b/%b want req%0d rdata=%h err=%b",
                         t, obs_done1, obs_done0, obs_rdata1, obs_rdata0, obs_err1, obs_err0,
                         exp_who, e_rdata, ae);
            end
            tests_run++;
            if (obs_stray !== 1'b0 || obs_idle_busy !== 1'b0) begin
                failed++;
                $display("FAIL rand%0d_sequence: got stray=%b idle_busy=%b want 0 0", t, obs_stray, obs_idle_busy);
            end
            last_served = exp_who;
            $display("[TB] txn rand #%0d req%0d rnw=%b addr=%h delay=%0d", t, exp_who, e_rnw, e_addr, dly);
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_timeout();
        int who, cyc, k;
        logic ab, d0, e0;
        logic [7:0] r0v;
        req0 = 1'b1;
        req1 = 1'b0;
        rnw0 = 1'b1;
        addr0 = 16'h0100;
        wait_grant(4, who, cyc);
        tests_run++;
        if (who !== 0) begin
            failed++;
            $display("FAIL timeout_grant: got who=%0d want 0", who);
        end
        req0 = 1'b0;
        tick();   // eng_start cycle: first cycle of WAIT
        k = -1;
        ab = 1'b0; d0 = 1'b0; e0 = 1'b0; r0v = 8'h00;
        for (int i = 1; i <= 150; i++) begin
            tick();
            if (done0 || done1 || eng_abort) begin
                k = i; ab = eng_abort; d0 = done0; e0 = err0; r0v = rdata0;
                break;
            end
        end
`ifdef IIC_ARB_TIMEOUT_EN
        tests_run++;
        if (k !== 100 || {ab, d0, e0, r0v} !== {1'b1, 1'b1, 1'b1, 8'h00}) begin
            failed++;
            $display("FAIL timeout_abort: got at cycle %0d abort=%b done0=%b err0=%b rdata0=%h want 100 1 1 1 00",
                     k, ab, d0, e0, r0v);
        end
        tick();
        tests_run++;
        if (eng_abort !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL timeout_after: got abort=%b busy=%b want 0 0", eng_abort, busy);
        end
`else
        tests_run++;
        if (k !== -1) begin
            failed++;
            $display("FAIL timeout_none: got completion at cycle %0d abort=%b want none", k, ab);
        end
        eng_done = 1'b1;
        eng_rdata = 8'h99;
        eng_ack_err = 1'b0;
        tick();
        eng_done = 1'b0;
        tests_run++;
        if ({done0, rdata0, err0} !== {1'b1, 8'h99, 1'b0}) begin
            failed++;
            $display("FAIL timeout_late_done: got done0=%b rdata0=%h err0=%b want 1 99 0", done0, rdata0, err0);
        end
        tick();
`endif
        last_served = 0;
        $display("[TB] txn timeout scenario on req0");
    endtask

    task automatic test_reset_mid();
        int who, cyc;
        req1 = 1'b1;
        rnw1 = 1'b1;
        addr1 = 16'h0333;
        wait_grant(4, who, cyc);
        tests_run++;
        if (who !== 1) begin
            failed++;
            $display("FAIL rstmid_grant: got who=%0d want 1", who);
        end
        req1 = 1'b0;
        tick();
        tick();   // now in WAIT
        rst = 1'b1;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tests_run++;
        if ({gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1, eng_start, eng_rnw,
             eng_addr, eng_wdata, eng_abort, busy} !== '0) begin
            failed++;
            $display("FAIL rstmid_outputs: got done=%b%b busy=%b rnw=%b addr=%h abort=%b want all 0",
                     done1, done0, busy, eng_rnw, eng_addr, eng_abort);
        end
        rst = 1'b0;
        last_served = 1;
        req0 = 1'b1;
        req1 = 1'b1;
        wait_grant(4, who, cyc);
        tests_run++;
        if (who !== model_pick(1'b1, 1'b1) || cyc !== 1) begin
            failed++;
            $display("FAIL rstmid_regrant: got who=%0d after %0d want who=0 after 1", who, cyc);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        drive_engine(0, 8'h11, 1'b0);
        tests_run++;
        if ({obs_done0, obs_done1} !== 2'b10) begin
            failed++;
            $display("FAIL rstmid_resp: got done0=%b done1=%b want 1 0", obs_done0, obs_done1);
        end
        last_served = 0;
        $display("[TB] txn reset mid-transaction then req0");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_err();
        test_busy_block();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
